// File: rtl/hsv_core_commit_arbiter_if.sv
// ---------------------------------------------------------------------------
// hsv_core_commit_pkg / hsv_core_commit_arbiter_if
//
// Purpose
//   commit_data_t payload definition plus the bundle of handshake signals
//   between the execution-unit skid buffers, the commit arbiter and the
//   commit stage.
//
// Interface signals (arbiter view, modport slave)
//   flush_req     in   pipeline flush request
//   flush_ack     out  flush acknowledge (1-cycle echo of flush_req)
//   unit_data_i   in   NUM_UNITS x commit_data_t per-unit result payload
//   unit_valid_i  in   NUM_UNITS per-unit payload valid
//   unit_ready_o  out  NUM_UNITS per-unit accept
//   commit_data   out  merged result to commit stage
//   valid_o       out  commit_data valid
//   ready_i       in   commit stage accepts
//   grant_count   out  NUM_UNITS x COUNT_W accepted-transfer counters
//                      (present only with HSV_COMMIT_ARB_STATS_EN defined)
//
// Modport master is the surrounding pipeline's (or a bench's) view.
// ---------------------------------------------------------------------------
package hsv_core_commit_pkg;

  typedef struct packed {
    logic [5:0]  rob_tag;
    logic [4:0]  rd_addr;
    logic [31:0] result;
    logic        exception;
  } commit_data_t;

endpackage

interface hsv_core_commit_arbiter_if #(
  parameter int NUM_UNITS = 3,
  parameter int COUNT_W   = 32
);
  import hsv_core_commit_pkg::*;

  logic                                flush_req;
  logic                                flush_ack;
  commit_data_t [NUM_UNITS-1:0]        unit_data_i;
  logic         [NUM_UNITS-1:0]        unit_valid_i;
  logic         [NUM_UNITS-1:0]        unit_ready_o;
  commit_data_t                        commit_data;
  logic                                valid_o;
  logic                                ready_i;
`ifdef HSV_COMMIT_ARB_STATS_EN
  logic [NUM_UNITS-1:0][COUNT_W-1:0]   grant_count;
`endif

  // Elaboration-time range guard on the configuration.
  if (NUM_UNITS < 2 || NUM_UNITS > 8 || COUNT_W < 1) begin : g_bad_cfg
    $error("hsv_core_commit_arbiter_if: unsupported NUM_UNITS/COUNT_W");
  end

  modport slave (
    input  flush_req,
    input  unit_data_i,
    input  unit_valid_i,
    input  ready_i,
    output flush_ack,
    output unit_ready_o,
    output commit_data,
`ifdef HSV_COMMIT_ARB_STATS_EN
    output grant_count,
`endif
    output valid_o
  );

  modport master (
    output flush_req,
    output unit_data_i,
    output unit_valid_i,
    output ready_i,
    input  flush_ack,
    input  unit_ready_o,
    input  commit_data,
`ifdef HSV_COMMIT_ARB_STATS_EN
    input  grant_count,
`endif
    input  valid_o
  );

endinterface

// File: rtl/hsv_core_commit_arbiter.sv
// ---------------------------------------------------------------------------
// hsv_core_commit_arbiter
//
// Purpose
//   Merges the result streams of the execution units into the single
//   commit_data_t stream consumed by the commit stage. Round-robin grant,
//   one registered output slot (full throughput on back-to-back transfers),
//   ready/valid on every side, flush_req/flush_ack shared with the units.
//
// Ports
//   clk_core     in   core clock
//   rst_core_n   in   asynchronous active-low reset
//   arb_if       slave modport of hsv_core_commit_arbiter_if carrying
//                flush_req/flush_ack, unit_data_i/unit_valid_i/unit_ready_o,
//                commit_data/valid_o/ready_i and (optionally) grant_count.
//
// Configuration
//   HSV_COMMIT_ARB_STATS_EN  when defined, per-unit saturating transfer
//                            counters are kept and driven on grant_count;
//                            they clear on reset only, never on flush.
// ---------------------------------------------------------------------------
module hsv_core_commit_arbiter
  import hsv_core_commit_pkg::*;
#(
  parameter int NUM_UNITS = 3,
  parameter int COUNT_W   = 32
) (
  input  logic                       clk_core,
  input  logic                       rst_core_n,
  hsv_core_commit_arbiter_if.slave   arb_if
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Elaboration-time range guard on the configuration.
  if (NUM_UNITS < 2 || NUM_UNITS > 8 || COUNT_W < 1) begin : g_bad_cfg
    $error("hsv_core_commit_arbiter: unsupported NUM_UNITS/COUNT_W");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                 valid_q,      valid_d;
  commit_data_t         data_q,       data_d;
  logic [PTR_W-1:0]     rr_ptr_q,     rr_ptr_d;
  logic                 flush_ack_q;

  // -------------------------------------------------------------------------
  // Combinational arbitration
  // -------------------------------------------------------------------------
  logic                 can_load;
  logic                 accept_en;
  logic [NUM_UNITS-1:0] grant_oh;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic [NUM_UNITS-1:0] xfer_oh;
  logic                 xfer;

  // The slot can take a new entry when it is empty or is being drained
  // this very cycle; that is what gives back-to-back transfers no bubble.
  assign can_load  = ~valid_q | arb_if.ready_i;
  assign accept_en = can_load & ~arb_if.flush_req;

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_UNITS and take the first valid
  // unit. The sum is one bit wider than the pointer so the wrap compare
  // cannot overflow for NUM_UNITS a power of two.
  always_comb begin
    logic [PTR_W:0] sum;
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_UNITS)) begin
        sum = sum - (PTR_W+1)'(NUM_UNITS);
      end
      if (!grant_vld && arb_if.unit_valid_i[sum[PTR_W-1:0]]) begin
        grant_vld                  = 1'b1;
        grant_idx                  = sum[PTR_W-1:0];
        grant_oh[sum[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

  // Only the granted unit ever sees ready, and never while idle, stalled
  // or flushing. Since a grant implies valid, ready alone marks a transfer.
  assign xfer_oh = grant_oh & {NUM_UNITS{accept_en}};
  assign xfer    = grant_vld & accept_en;

  // Next round-robin pointer: one past the unit that just transferred.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
    logic [PTR_W:0] nxt;
    nxt = {1'b0, idx} + (PTR_W+1)'(1);
    if (nxt >= (PTR_W+1)'(NUM_UNITS)) begin
      nxt = '0;
    end
    return nxt[PTR_W-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Next-state for the output slot and pointer
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    if (arb_if.flush_req) begin
      // Flush discards the slot even when it is stalled.
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d  = 1'b1;
      data_d   = arb_if.unit_data_i[grant_idx];
      rr_ptr_d = rr_next(grant_idx);
    end else if (valid_q && arb_if.ready_i) begin
      valid_d = 1'b0;
    end
  end

  // ---- stage boundary: registered output slot ----
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      flush_ack_q <= 1'b1;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      flush_ack_q <= arb_if.flush_req;
    end
  end

  assign arb_if.valid_o      = valid_q;
  assign arb_if.commit_data  = data_q;
  assign arb_if.flush_ack    = flush_ack_q;
  assign arb_if.unit_ready_o = xfer_oh;

`ifdef HSV_COMMIT_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Per-unit transfer statistics, saturating at all-ones.
  // -------------------------------------------------------------------------
  logic [NUM_UNITS-1:0][COUNT_W-1:0] grant_count_q;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // ---- stage boundary: statistics counters ----
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      grant_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (xfer_oh[i]) begin
          grant_count_q[i] <= sat_inc(grant_count_q[i]);
        end
      end
    end
  end

  assign arb_if.grant_count = grant_count_q;
`endif

endmodule
